mult_pipe_fu: RTL
=================

# mult_pipe_fu

Parametrised pipelined RV32M multiply functional unit, the next-generation multiplier FU for the execute stage. It accepts one MUL/MULH/MULHSU/MULHU operation per cycle from its reservation-station issue slot. It computes the full product over a configurable number of pipeline stages and presents the result, ROB number and destination PRN to the CDB priority selector. It adds three things the previous multiplier FU lacked: configurable depth and width, an explicit upstream accept signal, and a branch-misprediction squash.

## Interface
Parameters:
- XLEN, 32: operand/result width.
- NUM_STAGES, 4: pipeline depth. Must be ≥1 and must divide 2*XLEN.
- ROBN_W, 5: ROB index width.
- PRN_W, 6: physical register index width.

Ports:
- clock  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue a new op this cycle. Only legal when ready=1.
- rs1  in  XLEN  operand A, already muxed.
- rs2  in  XLEN  operand B, already muxed.
- func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- robn  in  ROBN_W  ROB tag carried with the op.
- dest_prn  in  PRN_W  destination PRN carried with the op.
- avail  in  1  CDB grant: the result on the outputs is consumed this cycle.
- squash  in  1  kill all in-flight ops (mispredict recovery).
- ready  out  1  the unit can accept start this cycle.
- done  out  1  a valid result is present on the outputs.
- result  out  XLEN  product slice selected by func.
- output_robn  out  ROBN_W  ROB tag of the result.
- output_dest_prn  out  PRN_W  destination PRN of the result.

## Operation
- Stage 0 captures the following:
  - rs1 extended to 2*XLEN: sign-extended for MULH/MULHSU, zero-extended otherwise.
  - rs2 extended to 2*XLEN: sign-extended for MULH only, zero-extended otherwise.
  - func, robn, dest_prn and a valid bit.
  - A zeroed 2*XLEN accumulator.
- Let W = 2*XLEN/NUM_STAGES. Stage k adds ext_a × ext_b[(k+1)*W-1 : k*W] << (k*W) into the accumulator. All arithmetic is mod 2^(2*XLEN).
- Final stage output: result = acc[XLEN-1:0] for MUL and acc[2*XLEN-1:XLEN] for the other three functions.
- done = valid bit of the final stage register.
- Stall condition is stall = done & ~avail.
  - While stall=1, every stage register holds its contents, including invalid bubbles.
  - While stall=1, ready=0.
- ready = ~stall, generated combinationally.
- If start=1 while ready=0, no entry is captured and the op is lost. Assertion-checked upstream.
- squash=1 clears every stage valid bit at the next edge and drops any start in the same cycle.
  - done=0 in the following cycle.
  - Data and tag fields do not need to be cleared.
- Priority order: reset > squash > stall > normal advance.

## Timing
- Reset values: done=0, ready=1, result=0, output_robn=0, output_dest_prn=0, all internal valid bits 0.
- Latency: start sampled at edge t gives done=1 with its result after edge t+NUM_STAGES-1, visible in cycle t+NUM_STAGES-1 (capture edge plus NUM_STAGES-1 advances). Fixed: exactly NUM_STAGES cycles from the start cycle to the done cycle, with no stalls.
- Throughput: one op per cycle; back-to-back starts produce back-to-back done.
- Each stall cycle adds one cycle to the latency of every in-flight op. Op order is preserved.
- When done=1 and avail=1 in the same cycle, the result is consumed. The pipeline advances, and the next op, if present, appears on the following cycle.
- An invalid final stage (done=0) never stalls, even if avail=0.
- Reset asserted mid-operation discards everything. The first cycle after reset deasserts has outputs at their reset values.
- squash and reset are sampled only at clock edges. Neither has any asynchronous effect.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (−3), robn=3, avail=1 → done after NUM_STAGES cycles with result=0xFFFFFFEB and output_robn=3.
- Four back-to-back ops:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 0×0x12345678 → 0.
  - Required: done high four consecutive cycles, results in issue order.
- Two ops in flight, avail=0 for 3 cycles once done=1 → ready=0 and outputs stable for 3 cycles; then avail=1 drains both with no loss or duplication.
- Three ops in flight, squash=1 with start=1 in the same cycle → done stays 0 for the next NUM_STAGES+1 cycles; a subsequent op completes normally.
- Reset pulsed for 1 cycle with 2 ops in flight → all outputs return to reset values, ready=1, and no stale done appears afterwards.
- Regression with NUM_STAGES∈{1,2,8} and 10k random operands/functions → every result matches a reference model.

Source files
------------

// File: rtl/mult_pipe_fu_if.sv
// mult_pipe_fu_if: issue, CDB and squash signals of the pipelined multiply FU.
//   master : issue slot / CDB side (drives start, operands, tags, avail, squash)
//   slave  : the FU (drives ready, done, result, output tags)
// Signals:
//   start, rs1, rs2, func, robn, dest_prn : op issued this cycle
//   avail                                 : CDB grant for the result on the outputs
//   squash                                : kill all in-flight ops
//   ready                                 : FU can take start this cycle
//   done, result, output_robn, output_dest_prn : completed op
interface mult_pipe_fu_if #(
  parameter int XLEN   = 32,
  parameter int ROBN_W = 5,
  parameter int PRN_W  = 6
);
  logic              start;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [1:0]        func;
  logic [ROBN_W-1:0] robn;
  logic [PRN_W-1:0]  dest_prn;
  logic              avail;
  logic              squash;
  logic              ready;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [ROBN_W-1:0] output_robn;
  logic [PRN_W-1:0]  output_dest_prn;

  modport master (
    output start, rs1, rs2, func, robn, dest_prn, avail, squash,
    input  ready, done, result, output_robn, output_dest_prn
  );

  modport slave (
    input  start, rs1, rs2, func, robn, dest_prn, avail, squash,
    output ready, done, result, output_robn, output_dest_prn
  );
endinterface

// File: rtl/mult_pipe_fu.sv
// mult_pipe_fu: pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
// The 2*XLEN product is built over NUM_STAGES stages, each adding one
// W-bit slice of the extended rs2 times the extended rs1.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   fu    : mult_pipe_fu_if slave (issue, CDB handshake, squash, result)
module mult_pipe_fu #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,
  parameter int ROBN_W     = 5,
  parameter int PRN_W      = 6
) (
  input logic           clock,
  input logic           reset,
  mult_pipe_fu_if.slave fu
);
  localparam int DW   = 2 * XLEN;
  localparam int W    = DW / NUM_STAGES;
  localparam int LAST = NUM_STAGES - 1;

  logic          done_w;
  logic          stall;
  logic          sign_a;
  logic          sign_b;
  logic [DW-1:0] ext_a;
  logic [DW-1:0] ext_b;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH
  assign sign_a = (fu.func == 2'b01) || (fu.func == 2'b10);
  assign sign_b = (fu.func == 2'b01);
  assign ext_a  = {{XLEN{sign_a & fu.rs1[XLEN-1]}}, fu.rs1};
  assign ext_b  = {{XLEN{sign_b & fu.rs2[XLEN-1]}}, fu.rs2};

  // a full result nobody takes freezes the whole pipe, bubbles included
  assign stall    = done_w & ~fu.avail;
  assign fu.ready = ~stall;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    // remaining (not yet consumed) multiplier bits entering this stage
    localparam int BW = DW - k * W;

    logic              vld_q;
    logic [1:0]        func_q;
    logic [ROBN_W-1:0] robn_q;
    logic [PRN_W-1:0]  prn_q;
    logic [DW-1:0]     acc_q;

    logic              v_in;
    logic [1:0]        f_in;
    logic [ROBN_W-1:0] robn_in;
    logic [PRN_W-1:0]  prn_in;
    logic [DW-1:0]     a_in;
    logic [BW-1:0]     b_in;
    logic [DW-1:0]     acc_in;
    logic [DW-1:0]     chunk;
    logic [DW-1:0]     pp;

    if (k == 0) begin : g_src
      assign v_in    = fu.start;
      assign f_in    = fu.func;
      assign robn_in = fu.robn;
      assign prn_in  = fu.dest_prn;
      assign a_in    = ext_a;
      assign b_in    = ext_b;
      assign acc_in  = '0;
    end else begin : g_src
      assign v_in    = g_stage[k-1].vld_q;
      assign f_in    = g_stage[k-1].func_q;
      assign robn_in = g_stage[k-1].robn_q;
      assign prn_in  = g_stage[k-1].prn_q;
      assign a_in    = g_stage[k-1].g_fwd.a_q;
      assign b_in    = g_stage[k-1].g_fwd.b_q;
      assign acc_in  = g_stage[k-1].acc_q;
    end

    // a_in already carries the k*W weight, so the low slice of b_in is
    // always the one to multiply here
    assign chunk = DW'(b_in[W-1:0]);
    assign pp    = a_in * chunk;

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_q  <= 1'b0;
        func_q <= '0;
        robn_q <= '0;
        prn_q  <= '0;
        acc_q  <= '0;
      end else if (fu.squash) begin
        vld_q <= 1'b0;
      end else if (!stall) begin
        vld_q  <= v_in;
        func_q <= f_in;
        robn_q <= robn_in;
        prn_q  <= prn_in;
        acc_q  <= acc_in + pp;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [DW-1:0]   a_q;
      logic [BW-W-1:0] b_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in << W;
          b_q <= b_in[BW-1:W];
        end
      end
    end else begin : g_out
      assign done_w             = vld_q;
      assign fu.done            = vld_q;
      assign fu.result          = (func_q == 2'b00) ? acc_q[XLEN-1:0] : acc_q[DW-1:XLEN];
      assign fu.output_robn     = robn_q;
      assign fu.output_dest_prn = prn_q;
    end
  end
endmodule
